branch_resolve_bht: RTL and testbench
=====================================

// Module: branch_resolve_bht
// PURPOSE
//  Parametrised successor to the funct3 branch selector. Resolves RV32 conditional
//  branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) internally from operands, registers the result,
//  and trains a 2-bit saturating-counter branch history table (BHT). Sits between
//  execute and fetch: fetch reads a prediction, execute resolves and flags mispredicts.
// PARAMETERS
//  XLEN      32  operand / PC width
//  IDX_BITS  4   BHT index width; BHT_ENTRIES = 2**IDX_BITS
//  CTR_INIT  1   reset value of every 2-bit counter (1 = weakly not-taken)
// PORTS
//  clk            in   1     system clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  lk_pc          in   XLEN  fetch-stage PC for prediction lookup
//  lk_taken       out  1     predicted taken for lk_pc (combinational)
//  rs_valid       in   1     resolve request valid this cycle
//  rs_pc          in   XLEN  PC of branch being resolved
//  rs_f3          in   3     funct3 of branch
//  rs_a           in   XLEN  rs1 operand
//  rs_b           in   XLEN  rs2 operand
//  rs_pred        in   1     prediction used at fetch for this branch
//  stall          in   1     hold pipeline stage
//  flush          in   1     kill stage contents
//  out_valid      out  1     registered result valid
//  out_taken      out  1     branch outcome
//  out_mispredict out  1     out_taken != rs_pred
//  out_illegal    out  1     rs_f3 was 010 or 011
// BEHAVIOUR
//  - Index = pc[IDX_BITS+1:2] for both lookup and update; upper PC bits ignored.
//  - lk_taken = bht[idx(lk_pc)][1]; pure read, zero latency.
//  - Conditions: 000 a==b; 001 a!=b; 100 signed a<b; 101 signed a>=b;
//    110 unsigned a<b; 111 unsigned a>=b; 010/011 illegal -> taken=0, illegal=1.
//  - Latency: one cycle; request at edge N appears on out_* after edge N.
//  - Per rising edge, priority flush > stall > rs_valid:
//    flush: out_valid<=0, other out_* <=0, no BHT update (even if rs_valid).
//    stall: all out_* hold, no BHT update, request ignored (upstream re-presents).
//    rs_valid: out_valid<=1, out_taken, out_illegal, out_mispredict<=taken^rs_pred;
//      legal f3: counter at idx(rs_pc) saturating +1 if taken (max 3), -1 if not (min 0);
//      illegal f3: no BHT update.
//    none: out_valid<=0, other out_* hold their last value.
//  - Same-cycle lookup and update to the same index: lk_taken shows pre-update value;
//    new value visible from next cycle.
//  - Only out_valid qualifies the other outputs.
//  - Reset (async, any time, incl. mid-request): all out_* =0 immediately; every counter
//    =CTR_INIT, so lk_taken = CTR_INIT[1]. Request in flight is dropped.
//  - Counters are 2 bits; no wrap: 3+1 stays 3, 0-1 stays 0.
// TESTING
//  1 Reset, lk_pc=0x100 -> lk_taken=0; all out_*=0.
//  2 BEQ a=5,b=5,pc=0x100,pred=0 -> next cycle valid=1,taken=1,mispredict=1; ctr[0]=2,
//    lk_taken(0x100)=1.
//  3 BLT a=0xFFFFFFFF,b=1 -> taken=1; BLTU same operands -> taken=0.
//  4 Four taken BNE at pc=0x104 -> ctr[1]=3 (saturates); then one not-taken -> ctr[1]=2,
//    lk_taken stays 1.
//  5 f3=010,pred=1 -> valid=1,illegal=1,taken=0,mispredict=1; ctr unchanged.
//  6 rs_valid with stall=1 -> outputs hold, ctr unchanged; with flush=1 and stall=1 ->
//    valid=0; async rst mid-cycle -> out_valid=0 before next edge.

Source files
------------

// File: rtl/branch_resolve_bht_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht_if
// Purpose : Bundles the fetch lookup, execute resolve request and registered
//           resolve result of branch_resolve_bht into one interface.
// Signals :
//   lk_pc          fetch PC to look up           (master -> slave)
//   lk_taken       predicted taken for lk_pc     (slave  -> master)
//   rs_valid       resolve request valid         (master -> slave)
//   rs_pc          PC of the resolving branch    (master -> slave)
//   rs_f3          branch funct3                 (master -> slave)
//   rs_a / rs_b    rs1 / rs2 operands            (master -> slave)
//   rs_pred        prediction used at fetch      (master -> slave)
//   stall / flush  stage hold / kill             (master -> slave)
//   out_valid      registered result valid       (slave  -> master)
//   out_taken      resolved outcome              (slave  -> master)
//   out_mispredict outcome differs from rs_pred  (slave  -> master)
//   out_illegal    funct3 was 010/011            (slave  -> master)
// ---------------------------------------------------------------------------
interface branch_resolve_bht_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lk_pc;
  logic            lk_taken;
  logic            rs_valid;
  logic [XLEN-1:0] rs_pc;
  logic [2:0]      rs_f3;
  logic [XLEN-1:0] rs_a;
  logic [XLEN-1:0] rs_b;
  logic            rs_pred;
  logic            stall;
  logic            flush;
  logic            out_valid;
  logic            out_taken;
  logic            out_mispredict;
  logic            out_illegal;

  modport master (
    output lk_pc, rs_valid, rs_pc, rs_f3, rs_a, rs_b, rs_pred, stall, flush,
    input  lk_taken, out_valid, out_taken, out_mispredict, out_illegal
  );

  modport slave (
    input  lk_pc, rs_valid, rs_pc, rs_f3, rs_a, rs_b, rs_pred, stall, flush,
    output lk_taken, out_valid, out_taken, out_mispredict, out_illegal
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht
// Purpose : Resolves RV32 conditional branches from their operands, registers
//           the outcome with mispredict/illegal flags, and trains a table of
//           2-bit saturating counters that fetch reads as its prediction.
// Ports   :
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset (outputs and all counters)
//   bus  slave modport of branch_resolve_bht_if (lookup, resolve, result)
// Parameters:
//   XLEN      operand / PC width
//   IDX_BITS  table index width, 2**IDX_BITS counters indexed by pc[IDX_BITS+1:2]
//   CTR_INIT  reset value of every counter
// ---------------------------------------------------------------------------
module branch_resolve_bht #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CTR_INIT = 1
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_bht_if.slave  bus
);
  localparam int         ENTRIES    = 1 << IDX_BITS;
  localparam logic [1:0] CTR_RST_VAL = 2'(CTR_INIT);

  logic [1:0]          r_bht [ENTRIES];
  logic                r_out_valid;
  logic                r_out_taken;
  logic                r_out_mispredict;
  logic                r_out_illegal;

  logic [IDX_BITS-1:0] w_lk_idx;
  logic [IDX_BITS-1:0] w_rs_idx;
  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic                w_eq;
  logic                w_lt_s;
  logic                w_lt_u;
  logic                w_taken;
  logic                w_illegal;
  logic                w_accept;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'd3)       nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'd0) nxt = ctr - 2'd1;
    return nxt;
  endfunction

  // Word-aligned index; bits [1:0] and anything above the index are ignored.
  assign w_lk_idx = bus.lk_pc[IDX_BITS+1:2];
  assign w_rs_idx = bus.rs_pc[IDX_BITS+1:2];

  // Pure read of the pre-update state, so a same-cycle update to the same
  // entry only shows from the next cycle.
  assign bus.lk_taken = r_bht[w_lk_idx][1];

  assign w_a_s  = signed'(bus.rs_a);
  assign w_b_s  = signed'(bus.rs_b);
  assign w_eq   = (bus.rs_a == bus.rs_b);
  assign w_lt_s = (w_a_s < w_b_s);
  assign w_lt_u = (bus.rs_a < bus.rs_b);

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (bus.rs_f3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt_s;
      3'b101:  w_taken = !w_lt_s;
      3'b110:  w_taken = w_lt_u;
      3'b111:  w_taken = !w_lt_u;
      default: w_illegal = 1'b1;
    endcase
  end

  // A request only takes effect when neither flush nor stall holds the stage.
  assign w_accept = bus.rs_valid && !bus.flush && !bus.stall;

  // Result register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_out_taken      <= 1'b0;
      r_out_mispredict <= 1'b0;
      r_out_illegal    <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid      <= 1'b0;
      r_out_taken      <= 1'b0;
      r_out_mispredict <= 1'b0;
      r_out_illegal    <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.rs_valid) begin
        r_out_valid      <= 1'b1;
        r_out_taken      <= w_taken;
        r_out_mispredict <= w_taken ^ bus.rs_pred;
        r_out_illegal    <= w_illegal;
      end else begin
        // Idle cycle: only the qualifier drops, payload keeps its last value.
        r_out_valid <= 1'b0;
      end
    end
  end

  // Counter training stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CTR_RST_VAL;
    end else if (w_accept && !w_illegal) begin
      r_bht[w_rs_idx] <= ctr_next(r_bht[w_rs_idx], w_taken);
    end
  end

  assign bus.out_valid      = r_out_valid;
  assign bus.out_taken      = r_out_taken;
  assign bus.out_mispredict = r_out_mispredict;
  assign bus.out_illegal    = r_out_illegal;
endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  branch_resolve_bht_if #(.XLEN(32)) bus ();

  branch_resolve_bht #(.XLEN(32), .IDX_BITS(4), .CTR_INIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: counters as plain ints, expected outputs as bits.
  int   m_ctr [16];
  logic m_valid, m_taken, m_misp, m_ill;

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, output bit ill);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ill = 0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: begin ill = 1; return 0; end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0;
    end else if (bus.stall) begin
      // hold everything
    end else if (bus.rs_valid) begin
      bit t, il;
      int k;
      t = m_cond(bus.rs_f3, bus.rs_a, bus.rs_b, il);
      m_valid = 1; m_taken = t; m_misp = t ^ bus.rs_pred; m_ill = il;
      k = int'((bus.rs_pc >> 2) % 16);
      if (!il) begin
        if (t) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
        else   m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
      end
    end else begin
      m_valid = 0;
    end
  end

  function automatic logic m_lk(input logic [31:0] pc);
    return m_ctr[int'((pc >> 2) % 16)] >= 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    check("lk_taken", 32'(bus.lk_taken), 32'(m_lk(bus.lk_pc)));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_taken", 32'(bus.out_taken), 32'(m_taken));
    check("out_mispredict", 32'(bus.out_mispredict), 32'(m_misp));
    check("out_illegal", 32'(bus.out_illegal), 32'(m_ill));
  end

  task automatic req(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic pred, input logic st, input logic fl);
    @(posedge clk); #1;
    bus.rs_valid = 1; bus.rs_pc = pc; bus.rs_f3 = f3; bus.rs_a = a; bus.rs_b = b;
    bus.rs_pred = pred; bus.stall = st; bus.flush = fl;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.rs_valid = 0; bus.stall = 0; bus.flush = 0;
  endtask

  initial begin
    bus.lk_pc = 32'h100; bus.rs_valid = 0; bus.rs_pc = 0; bus.rs_f3 = 0;
    bus.rs_a = 0; bus.rs_b = 0; bus.rs_pred = 0; bus.stall = 0; bus.flush = 0;
    repeat (2) @(negedge clk);
    // 1: reset state
    check("rst lk_taken", 32'(bus.lk_taken), 0);
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst out_taken", 32'(bus.out_taken), 0);
    @(posedge clk); #1 rst = 0;

    // 2: BEQ taken, predicted not-taken
    req(32'h100, 3'd0, 5, 5, 0, 0, 0);
    idle(); @(negedge clk);
    check("beq valid", 32'(bus.out_valid), 1);
    check("beq taken", 32'(bus.out_taken), 1);
    check("beq misp", 32'(bus.out_mispredict), 1);
    check("beq lk_taken", 32'(bus.lk_taken), 1);
    check("model ctr0", 32'(m_ctr[0]), 2);

    // 3: signed vs unsigned less-than
    req(32'h108, 3'd4, 32'hFFFF_FFFF, 1, 1, 0, 0);
    idle(); @(negedge clk);
    check("blt taken", 32'(bus.out_taken), 1);
    check("blt misp", 32'(bus.out_mispredict), 0);
    req(32'h108, 3'd6, 32'hFFFF_FFFF, 1, 0, 0, 0);
    idle(); @(negedge clk);
    check("bltu taken", 32'(bus.out_taken), 0);

    // 4: saturation at 3, then one step down
    bus.lk_pc = 32'h104;
    for (int i = 0; i < 4; i++) req(32'h104, 3'd1, 1, 2, 1, 0, 0);
    idle(); @(negedge clk);
    check("model ctr1 sat", 32'(m_ctr[1]), 3);
    check("bne lk_taken", 32'(bus.lk_taken), 1);
    req(32'h104, 3'd1, 7, 7, 1, 0, 0);
    idle(); @(negedge clk);
    check("model ctr1 dec", 32'(m_ctr[1]), 2);
    check("bne nt lk_taken", 32'(bus.lk_taken), 1);
    check("bne nt taken", 32'(bus.out_taken), 0);

    // 5: illegal funct3
    bus.lk_pc = 32'h10C;
    req(32'h10C, 3'd2, 3, 3, 1, 0, 0);
    idle(); @(negedge clk);
    check("ill valid", 32'(bus.out_valid), 1);
    check("ill flag", 32'(bus.out_illegal), 1);
    check("ill taken", 32'(bus.out_taken), 0);
    check("ill misp", 32'(bus.out_mispredict), 1);
    check("model ctr3", 32'(m_ctr[3]), 1);

    // 6: stall holds, flush kills, async reset drops in-flight result
    bus.lk_pc = 32'h100;
    req(32'h100, 3'd0, 5, 5, 1, 0, 0);
    req(32'h100, 3'd1, 1, 1, 1, 1, 0);
    idle(); @(negedge clk);
    check("stall valid", 32'(bus.out_valid), 1);
    check("stall taken", 32'(bus.out_taken), 1);
    check("stall misp", 32'(bus.out_mispredict), 0);
    check("model ctr0 stall", 32'(m_ctr[0]), 3);
    req(32'h100, 3'd0, 5, 5, 0, 1, 1);
    idle(); @(negedge clk);
    check("flush valid", 32'(bus.out_valid), 0);
    check("flush taken", 32'(bus.out_taken), 0);
    check("flush ctr0", 32'(m_ctr[0]), 3);
    req(32'h100, 3'd0, 5, 5, 0, 0, 0);
    idle();
    #1 check("pre-rst valid", 32'(bus.out_valid), 1);
    rst = 1;
    #1;
    check("async rst valid", 32'(bus.out_valid), 0);
    check("async rst taken", 32'(bus.out_taken), 0);
    check("async rst lk", 32'(bus.lk_taken), 0);
    @(posedge clk); #1 rst = 0;
    req(32'h100, 3'd0, 9, 9, 0, 0, 0);
    idle(); @(negedge clk);
    check("post-rst lk", 32'(bus.lk_taken), 1);
    check("post-rst valid", 32'(bus.out_valid), 1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
